// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants for the PWM generator
// Contents:
//   pwm_state_t          2-bit FSM state type
//   ST_IDLE/RUN/DRAIN    FSM state encodings
//   MIN_PERIOD           smallest period the counter will run with
package pwm_pkg;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t ST_IDLE  = 2'd0;
    localparam pwm_state_t ST_RUN   = 2'd1;
    localparam pwm_state_t ST_DRAIN = 2'd2;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_deadband.sv
// rtl/pwm_deadband.sv - dead-time insertion for complementary PWM outputs
// Ports:
//   PCLK, PRESET   clock, synchronous active-high reset
//   raw            registered duty-compare result
//   running        drive permission for the cycle being entered
//   dead_sh        shadowed dead time in PCLK cycles
//   pwm_h, pwm_l   high-side / low-side drive, never both 1
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DEAD_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              raw,
    input  logic              running,
    input  logic [DEAD_W-1:0] dead_sh,
    output logic              pwm_h,
    output logic              pwm_l
);

    logic              raw_d;
    logic [DEAD_W-1:0] dt_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            raw_d  <= 1'b0;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
        end else begin
            raw_d <= raw;
            if (raw != raw_d) begin
                // Every edge of raw (re)starts the blanking window.
                if (dead_sh == '0) begin
                    dt_cnt <= '0;
                    pwm_h  <= raw & running;
                    pwm_l  <= ~raw & running;
                end else begin
                    dt_cnt <= dead_sh;
                    pwm_h  <= 1'b0;
                    pwm_l  <= 1'b0;
                end
            end else if (dt_cnt > DEAD_W'(1)) begin
                dt_cnt <= dt_cnt - DEAD_W'(1);
                pwm_h  <= 1'b0;
                pwm_l  <= 1'b0;
            end else begin
                // Last blanking cycle or steady state: follow raw.
                dt_cnt <= '0;
                pwm_h  <= raw & running;
                pwm_l  <= ~raw & running;
            end
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - edge-aligned PWM generator with shadowed period/duty/dead time
// Ports:
//   PCLK, PRESET   clock, synchronous active-high reset
//   pwmenable      run request level
//   period_in      period in PCLK cycles (values below 2 run as 2)
//   duty_in        high time in PCLK cycles, latched by duty_valid
//   duty_valid     one-cycle strobe loading duty_in into the pending register
//   dead_time      blanking cycles around each output edge
//   pwm_h, pwm_l   complementary drives
//   period_start   pulse on cnt==0 while running
//   running        1 in RUN or DRAIN
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEAD_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              pwmenable,
    input  logic [CNT_W-1:0]  period_in,
    input  logic [CNT_W-1:0]  duty_in,
    input  logic              duty_valid,
    input  logic [DEAD_W-1:0] dead_time,
    output logic              pwm_h,
    output logic              pwm_l,
    output logic              period_start,
    output logic              running
);

    pwm_state_t        state;
    pwm_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_sh;
    logic [CNT_W-1:0]  duty_sh;
    logic [CNT_W-1:0]  pending;
    logic [CNT_W-1:0]  pending_nxt;
    logic [CNT_W-1:0]  period_clamped;
    logic [DEAD_W-1:0] dead_sh;
    logic              raw;
    logic              boundary;
    logic              reload;
    logic              drive_en;

    assign period_clamped = (period_in < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_in;

    // A strobe on the reload cycle must reach duty_sh directly.
    assign pending_nxt = duty_valid ? duty_in : pending;

    assign running      = (state != ST_IDLE);
    assign boundary     = running && (cnt == period_sh - CNT_W'(1));
    assign period_start = running && (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pwmenable) state_nxt = ST_RUN;
            ST_RUN:   if (!pwmenable) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (pwmenable)     state_nxt = ST_RUN;
                else if (boundary) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign reload = ((state == ST_IDLE) && pwmenable) || ((state == ST_RUN) && boundary);

    // The deadband sees the state being entered, so the DRAIN->IDLE edge
    // already turns both drives off for the first idle cycle.
    assign drive_en = (state_nxt != ST_IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            period_sh <= CNT_W'(MIN_PERIOD);
            duty_sh   <= '0;
            dead_sh   <= '0;
            pending   <= '0;
            raw       <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (reload) begin
                period_sh <= period_clamped;
                duty_sh   <= pending_nxt;
                dead_sh   <= dead_time;
            end
            if (!running || boundary) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // drive_en folds in the exit edge so raw is 0 throughout IDLE.
            raw <= running && drive_en && (cnt < duty_sh);
        end
    end

    pwm_deadband #(
        .DEAD_W (DEAD_W)
    ) u_deadband (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .raw     (raw),
        .running (drive_en),
        .dead_sh (dead_sh),
        .pwm_h   (pwm_h),
        .pwm_l   (pwm_l)
    );

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen
module tb_pwm_gen;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        pwmenable;
    logic [15:0] period_in;
    logic [15:0] duty_in;
    logic        duty_valid;
    logic [7:0]  dead_time;
    logic        pwm_h;
    logic        pwm_l;
    logic        period_start;
    logic        running;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 run, 2 drain
    int m_state, m_cnt, m_per, m_duty, m_dead, m_pend;
    bit m_raw, m_h, m_l;
    bit raw_hist [0:15];

    typedef struct {
        int per;
        int duty;
        int dead;
        int exp_h;
        int exp_l;
        int exp_s;
    } vec_t;

    always #5 PCLK = ~PCLK;

    pwm_gen dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .pwmenable    (pwmenable),
        .period_in    (period_in),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .dead_time    (dead_time),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_start (period_start),
        .running      (running)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_edge();
        int  nstate;
        bit  bnd;
        bit  ok;
        bit  raw_n;
        int  pend_n;
        int  cnt_n;
        if (PRESET) begin
            m_state = 0; m_cnt = 0; m_per = 2; m_duty = 0; m_dead = 0; m_pend = 0;
            m_raw = 0; m_h = 0; m_l = 0;
            for (int k = 0; k < 16; k++) raw_hist[k] = 0;
            return;
        end
        bnd    = (m_state != 0) && (m_cnt == m_per - 1);
        pend_n = duty_valid ? int'(duty_in) : m_pend;
        if (m_state == 0)      nstate = pwmenable ? 1 : 0;
        else if (m_state == 1) nstate = pwmenable ? 1 : 2;
        else                   nstate = pwmenable ? 1 : (bnd ? 0 : 2);
        // An output follows raw only once raw has been steady for dead+1 samples.
        ok = 1;
        for (int k = 1; k <= m_dead; k++) if (raw_hist[k] != raw_hist[0]) ok = 0;
        m_h = ok && m_raw && (nstate != 0);
        m_l = ok && !m_raw && (nstate != 0);
        raw_n = (m_state != 0) && (nstate != 0) && (m_cnt < m_duty);
        cnt_n = (m_state == 0 || bnd) ? 0 : m_cnt + 1;
        if ((m_state == 0 && pwmenable) || (m_state == 1 && bnd)) begin
            m_per  = (period_in < 2) ? 2 : int'(period_in);
            m_duty = pend_n;
            m_dead = int'(dead_time);
        end
        for (int k = 15; k > 0; k--) raw_hist[k] = raw_hist[k-1];
        raw_hist[0] = raw_n;
        m_raw   = raw_n;
        m_cnt   = cnt_n;
        m_pend  = pend_n;
        m_state = nstate;
    endtask

    task automatic step();
        @(posedge PCLK);
        model_edge();
        #1;
        check("pwm_h", pwm_h, m_h);
        check("pwm_l", pwm_l, m_l);
        check("running", running, m_state != 0);
        check("period_start", period_start, (m_state != 0) && (m_cnt == 0));
        check("no_overlap", pwm_h & pwm_l, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        PRESET = 1; pwmenable = 0; duty_valid = 0;
        step(); step();
        PRESET = 0;
    endtask

    task automatic wait_start(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (period_start) got = 1;
        end
        check(name, got, 1);
    endtask

    task automatic start_pwm(input int per, input int duty, input int dead);
        period_in = 16'(per); dead_time = 8'(dead);
        duty_in = 16'(duty); duty_valid = 1;
        step();
        duty_valid = 0; pwmenable = 1;
    endtask

    initial begin
        vec_t tbl [7];
        int   nh, nl, ns, len, n;
        int   runs [$];
        bit   seen, stayed;

        tbl[0] = '{10,  3, 0,  6, 14,  2};
        tbl[1] = '{10,  5, 2,  6,  6,  2};
        tbl[2] = '{10,  0, 0,  0, 20,  2};
        tbl[3] = '{10, 12, 0, 20,  0,  2};
        tbl[4] = '{ 0,  1, 0, 10, 10, 10};
        tbl[5] = '{ 1,  2, 0, 20,  0, 10};
        tbl[6] = '{ 4,  2, 1,  5,  5,  5};

        PRESET = 1; pwmenable = 0; period_in = 0; duty_in = 0; duty_valid = 0; dead_time = 0;
        do_reset();
        check("reset_h", pwm_h, 0);
        check("reset_l", pwm_l, 0);
        check("reset_running", running, 0);
        check("reset_start", period_start, 0);

        // Steady-state counts over 20 cycles per table row
        for (int r = 0; r < 7; r++) begin
            do_reset();
            start_pwm(tbl[r].per, tbl[r].duty, tbl[r].dead);
            run(40);
            nh = 0; nl = 0; ns = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                nh += int'(pwm_h); nl += int'(pwm_l); ns += int'(period_start);
            end
            check($sformatf("tbl%0d_h_count", r), nh, tbl[r].exp_h);
            check($sformatf("tbl%0d_l_count", r), nl, tbl[r].exp_l);
            check($sformatf("tbl%0d_start_count", r), ns, tbl[r].exp_s);
        end

        // Mid-period duty change 5->8 at cnt=4
        do_reset();
        start_pwm(10, 5, 0);
        run(25);
        wait_start("mid_wait");
        len = 0; runs = {};
        for (int i = 0; i < 30; i++) begin
            if (i == 4) begin duty_in = 8; duty_valid = 1; end else duty_valid = 0;
            step();
            if (pwm_h) len++;
            else if (len > 0) begin runs.push_back(len); len = 0; end
        end
        check("mid_runs", runs.size() >= 2, 1);
        if (runs.size() >= 2) begin
            check("mid_cur_width", runs[0], 5);
            check("mid_next_width", runs[1], 8);
        end

        // Strobe on the boundary cycle (cnt=9) lands in the next period
        wait_start("bnd_wait");
        len = 0; runs = {};
        for (int i = 0; i < 25; i++) begin
            if (i == 9) begin duty_in = 3; duty_valid = 1; end else duty_valid = 0;
            step();
            if (pwm_h) len++;
            else if (len > 0) begin runs.push_back(len); len = 0; end
        end
        check("bnd_runs", runs.size() >= 2, 1);
        if (runs.size() >= 2) begin
            check("bnd_cur_width", runs[0], 8);
            check("bnd_next_width", runs[1], 3);
        end

        // Enable drop at cnt=3: period completes, then idle
        do_reset();
        start_pwm(10, 5, 0);
        run(25);
        wait_start("drop_wait");
        run(3);
        pwmenable = 0;
        n = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            n++;
            if (!running) seen = 1;
        end
        check("drop_seen_idle", seen, 1);
        check("drop_cycles_to_idle", n, 7);
        check("drop_idle_h", pwm_h, 0);
        check("drop_idle_l", pwm_l, 0);

        // Drop at cnt=3, re-enable at cnt=6: cadence unchanged
        pwmenable = 1;
        run(25);
        wait_start("reen_wait");
        run(3);
        pwmenable = 0;
        run(3);
        pwmenable = 1;
        n = 0; seen = 0; stayed = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            n++;
            if (!running) stayed = 0;
            if (period_start) seen = 1;
        end
        check("reen_start_seen", seen, 1);
        check("reen_start_gap", n, 4);
        check("reen_no_idle", stayed, 1);

        // Reset while pwm_h is high
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (pwm_h) seen = 1;
        end
        check("rst_wait_h", seen, 1);
        PRESET = 1;
        step();
        check("rst_mid_h", pwm_h, 0);
        check("rst_mid_l", pwm_l, 0);
        check("rst_mid_running", running, 0);
        check("rst_mid_start", period_start, 0);
        PRESET = 0; pwmenable = 0;
        step();
        duty_in = 5; duty_valid = 1; pwmenable = 1;
        n = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            duty_valid = 0;
            n++;
            if (pwm_h) seen = 1;
        end
        check("restart_h_seen", seen, 1);
        check("restart_latency", n, 3);

        // Randomized segments against the model
        for (int s = 0; s < 4; s++) begin
            dead_time = 8'($urandom_range(0, 3));
            period_in = 16'($urandom_range(0, 12));
            pwmenable = 1;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 15) == 0) pwmenable = ~pwmenable;
                duty_valid = ($urandom_range(0, 3) == 0);
                duty_in = 16'($urandom_range(0, 14));
                if ($urandom_range(0, 31) == 0) period_in = 16'($urandom_range(0, 12));
                step();
            end
            duty_valid = 0; pwmenable = 0;
            run(30);
            check($sformatf("rand%0d_idle", s), running, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
